ex_muldiv_unit: RTL and testbench
=================================

EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits; legal range 8..64, even values only.
REQ-002 SHALL have parameter MUL_STAGES, default 2: multiply latency in cycles; legal range 1..4.
REQ-003 SHALL have parameter DIV_EARLY_TERM, default 1: when 1, short divides finish early.
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 flush  in  1  abort the operation in flight.
REQ-008 start  in  1  operation request; sampled only when busy=0.
REQ-009 op  in  3  0 MULT, 1 MULTU, 2 MADD, 3 MADDU, 4 MSUB, 5 MSUBU, 6 DIV, 7 DIVU.
REQ-010 a  in  WIDTH  operand 1 (dividend / multiplicand).
REQ-011 b  in  WIDTH  operand 2 (divisor / multiplier).
REQ-012 hilo_in  in  2*WIDTH  accumulator {hi,lo} for MADD/MSUB variants.
REQ-013 result  out  2*WIDTH  {hi,lo}; holds its value until the next completion.
REQ-014 busy  out  1  operation in flight; used as the EX stall request.
REQ-015 done  out  1  one-cycle pulse; result is valid from this cycle.
REQ-016 div_by_zero  out  1  pulses together with done when a divide had b==0.

Function
REQ-017 SHALL capture op, a, b and hilo_in on the edge where start=1, busy=0 and flush=0; later input changes SHALL have no effect on the operation.
REQ-018 SHALL implement FSM states IDLE, MUL, DIV, FIN; transitions: IDLE->MUL on accepted ops 0-5; IDLE->DIV on accepted ops 6-7 (or IDLE->FIN on early-term/zero divide); MUL->FIN after the stage count expires; DIV->FIN after WIDTH iterations; FIN->IDLE unconditionally.
REQ-019 SHALL assert busy in every cycle the FSM is outside IDLE, and SHALL deassert it in the FIN cycle so a new start is accepted there.
REQ-020 SHALL assert done only in FIN; with T the accept edge, done is high in cycle T+MUL_STAGES for multiplies and T+WIDTH+1 for full divides.
REQ-021 MULT/MADD/MSUB SHALL treat operands as signed; the U variants as unsigned; the product is the full 2*WIDTH bits.
REQ-022 MADD SHALL produce hilo_in + product and MSUB SHALL produce hilo_in - product, both modulo 2^(2*WIDTH).
REQ-023 Division SHALL be radix-2 restoring on magnitudes, with one quotient bit per cycle.
REQ-024 Signed divide SHALL truncate toward zero, with remainder sign equal to the dividend sign; result = {remainder, quotient}.
REQ-025 A signed divide of the most-negative value by -1 SHALL give lo = most-negative and hi = 0, with no flag.
REQ-026 b==0 on a divide SHALL complete at T+1 with hi=a, lo=all-ones and div_by_zero=1.
REQ-027 When DIV_EARLY_TERM=1 and |a|<|b| (b!=0), the divide SHALL complete at T+1 with lo=0 and hi=a.
REQ-028 flush SHALL return the FSM to IDLE at the next edge, with no done, no div_by_zero, and result unchanged.
REQ-029 flush and start in the same cycle SHALL be handled as flush; start SHALL be ignored.
REQ-030 start while busy=1 SHALL be ignored, with no queuing.
REQ-031 A flush arriving in the FIN cycle SHALL still let that completion's done and result stand.

Reset
REQ-032 rst SHALL force IDLE, result=0, busy=0, done=0 and div_by_zero=0 at the next edge, including mid-operation.
REQ-033 rst SHALL take priority over flush and start.

Verification (WIDTH=32, MUL_STAGES=2)
REQ-034 MULTU a=0xFFFFFFFF b=0xFFFFFFFF at T -> done at T+2, result=0xFFFFFFFE_00000001, busy high in T+1 only.
REQ-035 MADD hilo_in=0x10 a=0xFFFFFFFE b=3 -> result=0x00000000_0000000A; MSUBU hilo_in=0 a=1 b=1 -> result=0xFFFFFFFF_FFFFFFFF.
REQ-036 DIV a=0xFFFFFFF9 b=2 at T -> done at T+33, result=0xFFFFFFFF_FFFFFFFD; DIV a=0x80000000 b=0xFFFFFFFF -> result=0x00000000_80000000.
REQ-037 DIVU a=5 b=0 -> done and div_by_zero at T+1, result=0x00000005_FFFFFFFF; DIVU a=3 b=7 -> done at T+1, result=0x00000003_00000000.
REQ-038 DIVU started at T, flush at T+10 -> busy=0 at T+11, no done through T+40, result holds its prior value; a back-to-back start accepted in the FIN cycle of a MULT completes 2 cycles later.
REQ-039 rst asserted at T+5 of a DIV -> all outputs 0 at T+6; start=1 with flush=1 is ignored.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle multiply / multiply-accumulate / divide unit for the EX stage.
// Multiplies take MUL_STAGES cycles; divides use radix-2 restoring, one quotient bit per cycle.
module ex_muldiv_unit #(
    parameter int WIDTH          = 32,
    parameter int MUL_STAGES     = 2,
    parameter int DIV_EARLY_TERM = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2*WIDTH-1:0]   hilo_in,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy,
    output logic                 done,
    output logic                 div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] MUL_CNT = CW'((MUL_STAGES > 1) ? MUL_STAGES - 2 : 0);
    localparam logic [CW-1:0] DIV_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    state_t               state, state_nx;
    logic [2:0]           op_q;
    logic [WIDTH-1:0]     a_q, b_q;
    logic [2*WIDTH-1:0]   hilo_q;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     rem_q, quo_q, bmag_q;
    logic                 negq_q, negr_q, dbz_q;

    logic                 accept, is_mul_op, div_signed;
    logic                 a_neg, b_neg, div_zero, div_short;
    logic [WIDTH-1:0]     a_mag, b_mag;

    assign busy        = (state == MUL) || (state == DIV);
    assign done        = (state == FIN);
    assign div_by_zero = dbz_q;

    assign accept     = start && !busy && !flush;
    assign is_mul_op  = (op[2:1] != 2'b11);
    assign div_signed = (op == 3'd6);
    assign a_neg      = div_signed && a[WIDTH-1];
    assign b_neg      = div_signed && b[WIDTH-1];
    assign a_mag      = a_neg ? -a : a;
    assign b_mag      = b_neg ? -b : b;
    assign div_zero   = (b == '0);
    assign div_short  = (DIV_EARLY_TERM != 0) && (a_mag < b_mag);

    // Multiplier reads the captured operands while in MUL; a single-stage
    // multiply has no MUL cycle and takes its operands straight from the inputs.
    logic                 m_sel_reg, m_sgn;
    logic [2:0]           m_op;
    logic [WIDTH-1:0]     m_a, m_b;
    logic [2*WIDTH-1:0]   m_hilo, m_ea, m_eb, prod, mul_val;

    assign m_sel_reg = (state == MUL);
    assign m_op      = m_sel_reg ? op_q   : op;
    assign m_a       = m_sel_reg ? a_q    : a;
    assign m_b       = m_sel_reg ? b_q    : b;
    assign m_hilo    = m_sel_reg ? hilo_q : hilo_in;
    assign m_sgn     = ~m_op[0];
    assign m_ea      = {{WIDTH{m_sgn & m_a[WIDTH-1]}}, m_a};
    assign m_eb      = {{WIDTH{m_sgn & m_b[WIDTH-1]}}, m_b};
    assign prod      = m_ea * m_eb;

    always_comb begin
        mul_val = prod;
        case (m_op[2:1])
            2'b01:   mul_val = m_hilo + prod;
            2'b10:   mul_val = m_hilo - prod;
            default: mul_val = prod;
        endcase
    end

    // One restoring step: shift in the next dividend bit, keep the difference if it did not borrow.
    logic [WIDTH:0]       shifted, diff;
    logic [WIDTH-1:0]     rem_nx, quo_nx, q_fix, r_fix;

    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, bmag_q};
    assign rem_nx  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_nx  = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    assign q_fix   = negq_q ? -quo_nx : quo_nx;
    assign r_fix   = negr_q ? -rem_nx : rem_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, FIN: begin
                state_nx = IDLE;
                if (accept) begin
                    if (is_mul_op)
                        state_nx = (MUL_STAGES == 1) ? FIN : MUL;
                    else if (div_zero || div_short)
                        state_nx = FIN;
                    else
                        state_nx = DIV;
                end
            end
            MUL, DIV: begin
                if (flush)
                    state_nx = IDLE;
                else if (cnt == '0)
                    state_nx = FIN;
            end
            default: state_nx = IDLE;
        endcase
    end

    // result only changes on the edge entering FIN, so a flush mid-operation leaves it intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            result <= '0;
            dbz_q  <= 1'b0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            hilo_q <= '0;
            cnt    <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            bmag_q <= '0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
        end else begin
            state <= state_nx;
            dbz_q <= 1'b0;
            if (accept) begin
                op_q   <= op;
                a_q    <= a;
                b_q    <= b;
                hilo_q <= hilo_in;
                if (is_mul_op) begin
                    cnt <= MUL_CNT;
                    if (MUL_STAGES == 1)
                        result <= mul_val;
                end else if (div_zero) begin
                    result <= {a, {WIDTH{1'b1}}};
                    dbz_q  <= 1'b1;
                end else if (div_short) begin
                    result <= {a, {WIDTH{1'b0}}};
                end else begin
                    rem_q  <= '0;
                    quo_q  <= a_mag;
                    bmag_q <= b_mag;
                    negq_q <= a_neg ^ b_neg;
                    negr_q <= a_neg;
                    cnt    <= DIV_CNT;
                end
            end else if (!flush) begin
                if (state == MUL) begin
                    cnt <= cnt - CW'(1);
                    if (cnt == '0)
                        result <= mul_val;
                end else if (state == DIV) begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    cnt   <= cnt - CW'(1);
                    if (cnt == '0)
                        result <= {r_fix, q_fix};
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit (WIDTH=32, MUL_STAGES=2, early termination on).
// Directed vector table, hand-written multi-cycle sequences, then random ops against an arithmetic model.
module tb_ex_muldiv_unit;

    localparam int WIDTH      = 32;
    localparam int MUL_STAGES = 2;
    localparam int DIV_LAT    = WIDTH + 1;

    logic        clk = 1'b0;
    logic        rst, flush, start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [63:0] hilo_in, result;
    logic        busy, done, div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    ex_muldiv_unit #(.WIDTH(WIDTH), .MUL_STAGES(MUL_STAGES), .DIV_EARLY_TERM(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .start(start), .op(op),
        .a(a), .b(b), .hilo_in(hilo_in), .result(result),
        .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] hilo;
        logic [63:0] exp_res;
        int          exp_lat;
        logic        exp_dbz;
    } vec_t;

    vec_t vecs[15];

    // Reference behaviour computed with plain 64-bit arithmetic.
    function automatic logic [63:0] model_result(input logic [2:0] o, input logic [31:0] x,
                                                 input logic [31:0] y, input logic [63:0] h);
        longint          sx, sy, q, r;
        longint unsigned p;
        if (o < 3'd6) begin
            if (o[0] == 1'b0) begin
                sx = $signed(x);
                sy = $signed(y);
                p  = sx * sy;
            end else begin
                p = {32'b0, x} * {32'b0, y};
            end
            case (o[2:1])
                2'b00:   return p;
                2'b01:   return h + p;
                default: return h - p;
            endcase
        end
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        if (o == 3'd7) return {x % y, x / y};
        sx = $signed(x);
        sy = $signed(y);
        q  = sx / sy;
        r  = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int model_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint mx, my;
        if (o < 3'd6) return MUL_STAGES;
        if (y == 32'd0) return 1;
        if (o == 3'd6) begin
            mx = $signed(x);
            my = $signed(y);
            if (mx < 0) mx = -mx;
            if (my < 0) my = -my;
        end else begin
            mx = {32'b0, x};
            my = {32'b0, y};
        end
        return (mx < my) ? 1 : DIV_LAT;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single edge, then scrambles the inputs so late changes are exercised.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                 input logic [63:0] h);
        op = o; a = x; b = y; hilo_in = h; start = 1'b1;
        step();
        start = 1'b0;
        op = 3'($urandom);
        a = $urandom;
        b = $urandom;
        hilo_in = {$urandom, $urandom};
    endtask

    task automatic wait_done(input int lat0, output int lat, output int bad);
        lat = lat0;
        bad = 0;
        while (done !== 1'b1 && lat < 200) begin
            if (busy !== 1'b1 || div_by_zero !== 1'b0) bad++;
            step();
            lat++;
        end
        if (done !== 1'b1) lat = -1;
        else if (busy !== 1'b0) bad++;
    endtask

    task automatic run_check(input string name, input logic [2:0] o, input logic [31:0] x,
                             input logic [31:0] y, input logic [63:0] h, input logic [63:0] exp_res,
                             input int exp_lat, input logic exp_dbz);
        int lat, bad;
        applyStimulus(o, x, y, h);
        wait_done(1, lat, bad);
        checkOutput({name, " latency"}, 64'(lat), 64'(exp_lat));
        checkOutput({name, " result"}, result, exp_res);
        checkOutput({name, " div_by_zero"}, 64'(div_by_zero), 64'(exp_dbz));
        checkOutput({name, " busy protocol"}, 64'(bad), 64'd0);
        step();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat, bad;
        logic [2:0]  ro;
        logic [31:0] rx, ry;
        logic [63:0] rh;
        logic [31:0] edge_vals[5];
        edge_vals = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

        vecs[0]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0, 64'hFFFFFFFE_00000001, 2, 1'b0};
        vecs[1]  = '{3'd2, 32'hFFFFFFFE, 32'd3, 64'h10, 64'h00000000_0000000A, 2, 1'b0};
        vecs[2]  = '{3'd5, 32'd1, 32'd1, 64'd0, 64'hFFFFFFFF_FFFFFFFF, 2, 1'b0};
        vecs[3]  = '{3'd6, 32'hFFFFFFF9, 32'd2, 64'd0, 64'hFFFFFFFF_FFFFFFFD, 33, 1'b0};
        vecs[4]  = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 64'd0, 64'h00000000_80000000, 33, 1'b0};
        vecs[5]  = '{3'd7, 32'd5, 32'd0, 64'd0, 64'h00000005_FFFFFFFF, 1, 1'b1};
        vecs[6]  = '{3'd7, 32'd3, 32'd7, 64'd0, 64'h00000003_00000000, 1, 1'b0};
        vecs[7]  = '{3'd0, 32'hFFFFFFFD, 32'd5, 64'd0, 64'hFFFFFFFF_FFFFFFF1, 2, 1'b0};
        vecs[8]  = '{3'd4, 32'hFFFFFFFC, 32'd5, 64'd100, 64'h00000000_00000078, 2, 1'b0};
        vecs[9]  = '{3'd3, 32'd1, 32'd1, 64'hFFFFFFFF_FFFFFFFF, 64'd0, 2, 1'b0};
        vecs[10] = '{3'd7, 32'd100, 32'd7, 64'd0, 64'h00000002_0000000E, 33, 1'b0};
        vecs[11] = '{3'd6, 32'd7, 32'hFFFFFFFE, 64'd0, 64'h00000001_FFFFFFFD, 33, 1'b0};
        vecs[12] = '{3'd6, 32'hFFFFFFFB, 32'd0, 64'd0, 64'hFFFFFFFB_FFFFFFFF, 1, 1'b1};
        vecs[13] = '{3'd6, 32'd3, 32'hFFFFFFF9, 64'd0, 64'h00000003_00000000, 1, 1'b0};
        vecs[14] = '{3'd6, 32'hFFFFFFF9, 32'd7, 64'd0, 64'h00000000_FFFFFFFF, 33, 1'b0};

        rst = 1'b1; flush = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; hilo_in = '0;
        repeat (3) step();
        checkOutput("reset result", result, 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset div_by_zero", 64'(div_by_zero), 64'd0);
        rst = 1'b0;
        step();

        // start together with flush must be dropped
        flush = 1'b1; start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd4;
        step();
        flush = 1'b0; start = 1'b0;
        bad = 0;
        repeat (4) begin
            if (busy !== 1'b0 || done !== 1'b0) bad++;
            step();
        end
        checkOutput("start_with_flush ignored", 64'(bad), 64'd0);
        checkOutput("start_with_flush result", result, 64'd0);

        for (int i = 0; i < 15; i++)
            run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hilo,
                      vecs[i].exp_res, vecs[i].exp_lat, vecs[i].exp_dbz);

        // flush in the middle of a divide
        run_check("pre_flush multu", 3'd1, 32'd6, 32'd7, 64'd0, 64'd42, 2, 1'b0);
        applyStimulus(3'd7, 32'd1000, 32'd3, 64'd0);
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checkOutput("flush busy dropped", 64'(busy), 64'd0);
        bad = 0;
        repeat (30) begin
            if (done !== 1'b0 || div_by_zero !== 1'b0) bad++;
            step();
        end
        checkOutput("flush no done", 64'(bad), 64'd0);
        checkOutput("flush result held", result, 64'd42);

        // back-to-back start in the FIN cycle of a MULT
        applyStimulus(3'd0, 32'hFFFFFFFD, 32'd5, 64'd0);
        wait_done(1, lat, bad);
        checkOutput("b2b first latency", 64'(lat), 64'd2);
        checkOutput("b2b first result", result, 64'hFFFFFFFF_FFFFFFF1);
        applyStimulus(3'd0, 32'd7, 32'd6, 64'd0);
        wait_done(1, lat, bad);
        checkOutput("b2b second latency", 64'(lat), 64'd2);
        checkOutput("b2b second result", result, 64'h2A);
        checkOutput("b2b busy protocol", 64'(bad), 64'd0);
        step();

        // start while busy is ignored and not queued
        applyStimulus(3'd7, 32'd100, 32'd7, 64'd0);
        step();
        start = 1'b1; op = 3'd1; a = 32'd2; b = 32'd2;
        step();
        start = 1'b0;
        wait_done(3, lat, bad);
        checkOutput("busy_start latency", 64'(lat), 64'd33);
        checkOutput("busy_start result", result, 64'h00000002_0000000E);
        step();
        bad = 0;
        repeat (5) begin
            if (done !== 1'b0 || busy !== 1'b0) bad++;
            step();
        end
        checkOutput("busy_start not queued", 64'(bad), 64'd0);

        // flush during FIN keeps the completion
        applyStimulus(3'd1, 32'd6, 32'd9, 64'd0);
        step();
        flush = 1'b1;
        #1;
        checkOutput("fin_flush done", 64'(done), 64'd1);
        checkOutput("fin_flush result", result, 64'h36);
        step();
        flush = 1'b0;
        checkOutput("fin_flush idle", 64'({busy, done}), 64'd0);
        checkOutput("fin_flush result kept", result, 64'h36);

        // reset in the middle of a signed divide
        applyStimulus(3'd6, 32'd1000, 32'd7, 64'd0);
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("mid_rst result", result, 64'd0);
        checkOutput("mid_rst flags", 64'({busy, done, div_by_zero}), 64'd0);
        step();

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: begin rx = $urandom; ry = $urandom; end
                1: begin rx = $urandom; ry = 32'($urandom_range(0, 3)); end
                2: begin rx = 32'($urandom_range(0, 255)); ry = $urandom; end
                default: begin
                    rx = edge_vals[$urandom_range(0, 4)];
                    ry = edge_vals[$urandom_range(0, 4)];
                end
            endcase
            rh = {$urandom, $urandom};
            run_check($sformatf("rand%0d op%0d", i, ro), ro, rx, ry, rh, model_result(ro, rx, ry, rh),
                      model_lat(ro, rx, ry), (ro >= 3'd6) && (ry == 32'd0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
